scene_mem_arbiter: RTL and testbench
====================================

# scene_mem_arbiter

Shares the single scene-memory port (shape/light records) between two requesters. The instruction-execute path writes scene records; the raytracing controller reads them for raycasting. The block sits between both requesters and the scene BRAM. It serialises accesses one per cycle, bounds read starvation, tracks read latency, and tells the raytracer when the memory is quiescent.

## Interface
Parameters:
- ADDR_W, 4, scene record address width (covers ShapeAddr and LightAddr space)
- DATA_W, 128, scene record width in bits
- READ_LATENCY, 2, BRAM read latency in cycles (≥1)
- STARVE_LIMIT, 4, consecutive denied read cycles before the read is forced to win

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wr_req  in  1  execute-path write request; held until wr_ack
- wr_addr  in  ADDR_W  write address; stable while wr_req
- wr_data  in  DATA_W  write record; stable while wr_req
- wr_ack  out  1  one-cycle pulse: write performed this cycle
- rd_req  in  1  raytracer read request; held until rd_gnt
- rd_addr  in  ADDR_W  read address; stable while rd_req
- rd_gnt  out  1  one-cycle pulse: read issued to memory this cycle
- rd_valid  out  1  pulse READ_LATENCY cycles after rd_gnt
- rd_data  out  DATA_W  read record, valid while rd_valid
- mem_en  out  1  BRAM enable
- mem_we  out  1  BRAM write enable
- mem_addr  out  ADDR_W  BRAM address
- mem_wdata  out  DATA_W  BRAM write data
- mem_rdata  in  DATA_W  BRAM read data
- mem_ready  out  1  high when no write is pending and no read is in flight

## Operation
- At most one memory access per cycle. Grant decision is combinational from wr_req, rd_req and the starvation counter.
- Default priority: write wins.
- The read wins instead when rd_req is high and starve_cnt == STARVE_LIMIT.
- starve_cnt (width clog2(STARVE_LIMIT+1)):
  - increments when rd_req is high and the read is not granted
  - resets to 0 on rd_gnt or when rd_req is low
  - saturates at STARVE_LIMIT
- Write grant: mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, wr_ack=1.
- Read grant: mem_en=1, mem_we=0, mem_addr=rd_addr, rd_gnt=1. A 1 is shifted into the valid delay line.
- With no grant: mem_en=0, mem_we=0. mem_addr and mem_wdata are don't-care, driven 0.
- rd_data = mem_rdata, passed through combinationally. rd_valid = delay-line tap READ_LATENCY-1.
- Reads may be issued back-to-back. Up to READ_LATENCY reads are in flight, and rd_valid pulses appear in grant order.
- Ordering:
  - A write acked in cycle N is visible to any read granted in cycle N+1 or later.
  - Same-address write and read requested in the same cycle: write first, read next cycle, read returns new data.
- mem_ready = !wr_req && (delay line all zero).

## Timing
- Reset: wr_ack, rd_gnt, rd_valid, mem_en, mem_we = 0. mem_addr and mem_wdata = 0. starve_cnt = 0. Delay line cleared.
- Reads in flight at reset are discarded: no rd_valid is produced for them.
- mem_ready is 1 one cycle after rst deasserts if wr_req is low.
- Uncontended read: rd_gnt in the cycle rd_req is first sampled high. rd_valid READ_LATENCY cycles later.
- Uncontended write: wr_ack in the first cycle wr_req is high.
- Contended (wr_req held continuously): read denied STARVE_LIMIT cycles, then granted on the next cycle. Worst-case read grant latency is STARVE_LIMIT+1 cycles.
- Requester must drop req the cycle after ack/gnt, or the held req is treated as a new request.
- rst during an active request: the request is not acked that cycle. The requester must re-present it after reset.

## Structure
- Package proctypes gains SCENE_ADDR_W, SCENE_DATA_W and the SceneAddr/SceneRecord typedefs. Shape and Light records are cast to SceneRecord.
- One sub-module: valid_delay_line (parameter DEPTH), a shift register of valid bits with a synchronous clear, plus an any_valid output used for mem_ready.

## Test plan
- Reset mid-flight: rd_gnt at cycle 0 with READ_LATENCY=2, rst at cycle 1 -> no rd_valid at cycle 2, all outputs 0, mem_ready=1 after reset.
- Isolated read: rd_req, rd_addr=3, BRAM[3]=0xABCD -> rd_gnt cycle 0, rd_valid with rd_data=0xABCD at cycle 2, mem_ready low on cycles 1-2.
- Write then read same address: wr_req and rd_req both to addr 5 in cycle 0, wr_data=0x1234 -> wr_ack cycle 0, rd_gnt cycle 1, rd_data=0x1234 at cycle 3.
- Starvation: wr_req held 10 cycles, rd_req from cycle 0, STARVE_LIMIT=4 -> wr_ack cycles 0-3, rd_gnt cycle 4, wr_ack resumes cycle 5.
- Back-to-back reads to addrs 0, 1, 2 on consecutive cycles -> three rd_valid pulses on cycles 2, 3, 4 with matching data order.

Source files
------------

// File: rtl/scene_mem_arbiter_pkg.sv
// Shared types for the scene-memory arbiter: record/address widths and the
// per-cycle grant encoding.
package scene_mem_arbiter_pkg;

  localparam int SCENE_ADDR_W = 4;
  localparam int SCENE_DATA_W = 128;

  // Shape and light records are both carried as a SceneRecord.
  typedef logic [SCENE_ADDR_W-1:0] SceneAddr;
  typedef logic [SCENE_DATA_W-1:0] SceneRecord;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } grant_e;

  function automatic int starve_cnt_w(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/scene_mem_arbiter_if.sv
// Bundle of the write requester, read requester and scene BRAM port signals.
interface scene_mem_arbiter_if
  import scene_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = SCENE_ADDR_W,
  parameter int DATA_W = SCENE_DATA_W
);

  // Handshake: a requester holds req (with stable addr/data) until the
  // arbiter answers with a one-cycle wr_ack / rd_gnt in the cycle the access
  // reaches memory; req must drop the next cycle or it counts as a new request.
  // rd_valid pulses once per rd_gnt, in grant order, with rd_data alongside.
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_rdata,
    input  wr_ack, rd_gnt, rd_valid, rd_data,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_ready
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_rdata,
    output wr_ack, rd_gnt, rd_valid, rd_data,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_ready
  );

endinterface

// File: rtl/scene_mem_arbiter_valid_delay_line.sv
// Shift register of read-valid bits matching the BRAM read latency; the last
// stage marks the cycle the read data is on mem_rdata.
module valid_delay_line
  import scene_mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic clear_i,
  input  logic shift_in_i,
  output logic valid_o,
  output logic any_valid_o
);

  logic [DEPTH-1:0] line_q;
  logic [DEPTH-1:0] line_d;

  always_comb begin
    line_d    = line_q;
    line_d[0] = shift_in_i;
    for (int i = 1; i < DEPTH; i++) begin
      line_d[i] = line_q[i-1];
    end
  end

  // Clearing drops in-flight reads so no stale rd_valid escapes a reset.
  always_ff @(posedge clk) begin
    if (clear_i) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign valid_o     = line_q[DEPTH-1];
  assign any_valid_o = |line_q;

endmodule

// File: rtl/scene_mem_arbiter.sv
// Serialises execute-path writes and raytracer reads onto the single scene
// BRAM port: write-first priority with a bounded read starvation window.
module scene_mem_arbiter
  import scene_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = SCENE_ADDR_W,
  parameter int DATA_W       = SCENE_DATA_W,
  parameter int READ_LATENCY = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                rst,
  scene_mem_arbiter_if.slave arb
);

  localparam int                CNT_W   = starve_cnt_w(STARVE_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]  starve_q;
  logic [CNT_W-1:0]  starve_d;
  grant_e            grant;
  logic              read_forced;
  logic              gnt_wr;
  logic              gnt_rd;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;
  logic              rd_valid_tap;
  logic              reads_in_flight;

  // Grants are suppressed during reset so a request held across rst is not acked.
  always_comb begin
    read_forced = arb.rd_req && (starve_q == CNT_MAX);
    grant       = GNT_NONE;
    if (!rst) begin
      if (arb.wr_req && !read_forced) begin
        grant = GNT_WR;
      end else if (arb.rd_req) begin
        grant = GNT_RD;
      end
    end
  end

  assign gnt_wr = (grant == GNT_WR);
  assign gnt_rd = (grant == GNT_RD);

  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    if (gnt_wr) begin
      addr_mux  = arb.wr_addr;
      wdata_mux = arb.wr_data;
    end else if (gnt_rd) begin
      addr_mux  = arb.rd_addr;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!arb.rd_req || gnt_rd) begin
      starve_d = '0;
    end else if (starve_q != CNT_MAX) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  valid_delay_line #(
    .DEPTH (READ_LATENCY)
  ) u_valid_delay_line (
    .clk         (clk),
    .clear_i     (rst),
    .shift_in_i  (gnt_rd),
    .valid_o     (rd_valid_tap),
    .any_valid_o (reads_in_flight)
  );

  assign arb.wr_ack    = gnt_wr;
  assign arb.rd_gnt    = gnt_rd;
  assign arb.mem_en    = gnt_wr || gnt_rd;
  assign arb.mem_we    = gnt_wr;
  assign arb.mem_addr  = addr_mux;
  assign arb.mem_wdata = wdata_mux;
  assign arb.rd_valid  = rd_valid_tap;
  assign arb.rd_data   = arb.mem_rdata;
  assign arb.mem_ready = !arb.wr_req && !reads_in_flight;

endmodule

// File: tb/tb_scene_mem_arbiter.sv
// Directed bench for scene_mem_arbiter with a two-cycle BRAM model.
module tb_scene_mem_arbiter;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 128;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] bram [16];
  logic [DATA_W-1:0] bram_stage;

  scene_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  scene_mem_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .READ_LATENCY (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .arb (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM: write on the enable edge, read data appears two edges after issue.
  always @(posedge clk) begin
    bus.mem_rdata = bram_stage;
    if (bus.mem_en && !bus.mem_we) bram_stage = bram[bus.mem_addr];
    if (bus.mem_en && bus.mem_we) bram[bus.mem_addr] = bus.mem_wdata;
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.wr_req  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_req  = 1'b0;
    bus.rd_addr = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    next_cycle();
    rst = 1'b1;
    bus.wr_req = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = 128'h55;
    bus.rd_req = 1'b1; bus.rd_addr = 4'd3;
    @(negedge clk);
    total_cnt++; if (bus.wr_ack !== 1'b0) $display("FAIL reset_wr_ack got=%0b want=0", bus.wr_ack); else pass_cnt++;
    total_cnt++; if (bus.rd_gnt !== 1'b0) $display("FAIL reset_rd_gnt got=%0b want=0", bus.rd_gnt); else pass_cnt++;
    total_cnt++; if (bus.mem_en !== 1'b0) $display("FAIL reset_mem_en got=%0b want=0", bus.mem_en); else pass_cnt++;
    total_cnt++; if (bus.mem_we !== 1'b0) $display("FAIL reset_mem_we got=%0b want=0", bus.mem_we); else pass_cnt++;
    total_cnt++; if (bus.mem_addr !== 4'd0) $display("FAIL reset_mem_addr got=%0h want=0", bus.mem_addr); else pass_cnt++;
    total_cnt++; if (bus.mem_wdata !== 128'd0) $display("FAIL reset_mem_wdata got=%0h want=0", bus.mem_wdata); else pass_cnt++;
    next_cycle();
    rst = 1'b0;
    set_idle();
    @(negedge clk);
    total_cnt++; if (bus.rd_valid !== 1'b0) $display("FAIL reset_rd_valid got=%0b want=0", bus.rd_valid); else pass_cnt++;
    total_cnt++; if (bus.mem_ready !== 1'b1) $display("FAIL reset_mem_ready got=%0b want=1", bus.mem_ready); else pass_cnt++;
  endtask

  task automatic test_reset_mid_flight();
    next_cycle();
    bus.rd_req = 1'b1; bus.rd_addr = 4'd3;
    @(negedge clk);
    total_cnt++; if (bus.rd_gnt !== 1'b1) $display("FAIL midrst_gnt got=%0b want=1", bus.rd_gnt); else pass_cnt++;
    next_cycle();
    set_idle();
    rst = 1'b1;
    @(negedge clk);
    total_cnt++; if (bus.rd_valid !== 1'b0) $display("FAIL midrst_valid_c1 got=%0b want=0", bus.rd_valid); else pass_cnt++;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    total_cnt++; if (bus.rd_valid !== 1'b0) $display("FAIL midrst_valid_c2 got=%0b want=0", bus.rd_valid); else pass_cnt++;
    total_cnt++; if (bus.mem_en !== 1'b0) $display("FAIL midrst_mem_en got=%0b want=0", bus.mem_en); else pass_cnt++;
    total_cnt++; if (bus.mem_ready !== 1'b1) $display("FAIL midrst_ready got=%0b want=1", bus.mem_ready); else pass_cnt++;
    next_cycle();
    @(negedge clk);
    total_cnt++; if (bus.rd_valid !== 1'b0) $display("FAIL midrst_valid_c3 got=%0b want=0", bus.rd_valid); else pass_cnt++;
  endtask

  task automatic test_isolated_read();
    next_cycle();
    bus.rd_req = 1'b1; bus.rd_addr = 4'd3;
    @(negedge clk);
    total_cnt++; if (bus.rd_gnt !== 1'b1) $display("FAIL iso_gnt got=%0b want=1", bus.rd_gnt); else pass_cnt++;
    total_cnt++; if (bus.mem_en !== 1'b1) $display("FAIL iso_mem_en got=%0b want=1", bus.mem_en); else pass_cnt++;
    total_cnt++; if (bus.mem_we !== 1'b0) $display("FAIL iso_mem_we got=%0b want=0", bus.mem_we); else pass_cnt++;
    total_cnt++; if (bus.mem_addr !== 4'd3) $display("FAIL iso_mem_addr got=%0h want=3", bus.mem_addr); else pass_cnt++;
    total_cnt++; if (bus.wr_ack !== 1'b0) $display("FAIL iso_wr_ack got=%0b want=0", bus.wr_ack); else pass_cnt++;
    next_cycle();
    set_idle();
    @(negedge clk);
    total_cnt++; if (bus.mem_ready !== 1'b0) $display("FAIL iso_ready_c1 got=%0b want=0", bus.mem_ready); else pass_cnt++;
    total_cnt++; if (bus.rd_valid !== 1'b0) $display("FAIL iso_valid_c1 got=%0b want=0", bus.rd_valid); else pass_cnt++;
    next_cycle();
    @(negedge clk);
    total_cnt++; if (bus.rd_valid !== 1'b1) $display("FAIL iso_valid_c2 got=%0b want=1", bus.rd_valid); else pass_cnt++;
    total_cnt++; if (bus.rd_data !== 128'hABCD) $display("FAIL iso_data got=%0h want=abcd", bus.rd_data); else pass_cnt++;
    total_cnt++; if (bus.mem_ready !== 1'b0) $display("FAIL iso_ready_c2 got=%0b want=0", bus.mem_ready); else pass_cnt++;
    next_cycle();
    @(negedge clk);
    total_cnt++; if (bus.rd_valid !== 1'b0) $display("FAIL iso_valid_c3 got=%0b want=0", bus.rd_valid); else pass_cnt++;
    total_cnt++; if (bus.mem_ready !== 1'b1) $display("FAIL iso_ready_c3 got=%0b want=1", bus.mem_ready); else pass_cnt++;
  endtask

  task automatic test_write_then_read();
    next_cycle();
    bus.wr_req = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 128'h1234;
    bus.rd_req = 1'b1; bus.rd_addr = 4'd5;
    @(negedge clk);
    total_cnt++; if (bus.wr_ack !== 1'b1) $display("FAIL wtr_ack_c0 got=%0b want=1", bus.wr_ack); else pass_cnt++;
    total_cnt++; if (bus.rd_gnt !== 1'b0) $display("FAIL wtr_gnt_c0 got=%0b want=0", bus.rd_gnt); else pass_cnt++;
    total_cnt++; if (bus.mem_we !== 1'b1) $display("FAIL wtr_we_c0 got=%0b want=1", bus.mem_we); else pass_cnt++;
    total_cnt++; if (bus.mem_addr !== 4'd5) $display("FAIL wtr_addr_c0 got=%0h want=5", bus.mem_addr); else pass_cnt++;
    total_cnt++; if (bus.mem_wdata !== 128'h1234) $display("FAIL wtr_wdata_c0 got=%0h want=1234", bus.mem_wdata); else pass_cnt++;
    total_cnt++; if (bus.mem_ready !== 1'b0) $display("FAIL wtr_ready_c0 got=%0b want=0", bus.mem_ready); else pass_cnt++;
    next_cycle();
    bus.wr_req = 1'b0;
    @(negedge clk);
    total_cnt++; if (bus.rd_gnt !== 1'b1) $display("FAIL wtr_gnt_c1 got=%0b want=1", bus.rd_gnt); else pass_cnt++;
    total_cnt++; if (bus.wr_ack !== 1'b0) $display("FAIL wtr_ack_c1 got=%0b want=0", bus.wr_ack); else pass_cnt++;
    next_cycle();
    set_idle();
    @(negedge clk);
    total_cnt++; if (bus.rd_valid !== 1'b0) $display("FAIL wtr_valid_c2 got=%0b want=0", bus.rd_valid); else pass_cnt++;
    next_cycle();
    @(negedge clk);
    total_cnt++; if (bus.rd_valid !== 1'b1) $display("FAIL wtr_valid_c3 got=%0b want=1", bus.rd_valid); else pass_cnt++;
    total_cnt++; if (bus.rd_data !== 128'h1234) $display("FAIL wtr_data_c3 got=%0h want=1234", bus.rd_data); else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_starvation();
    logic rd_done;
    logic exp_gnt;
    rd_done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      bus.wr_req  = 1'b1; bus.wr_addr = 4'd9; bus.wr_data = 128'(c + 100);
      bus.rd_req  = !rd_done; bus.rd_addr = 4'd3;
      @(negedge clk);
      exp_gnt = (c == 4);
      total_cnt++; if (bus.rd_gnt !== exp_gnt) $display("FAIL starve_gnt_c%0d got=%0b want=%0b", c, bus.rd_gnt, exp_gnt); else pass_cnt++;
      total_cnt++; if (bus.wr_ack !== !exp_gnt) $display("FAIL starve_ack_c%0d got=%0b want=%0b", c, bus.wr_ack, !exp_gnt); else pass_cnt++;
      total_cnt++; if (bus.rd_valid !== (c == 6)) $display("FAIL starve_valid_c%0d got=%0b want=%0b", c, bus.rd_valid, (c == 6)); else pass_cnt++;
      if (c == 6) begin
        total_cnt++; if (bus.rd_data !== 128'hABCD) $display("FAIL starve_data got=%0h want=abcd", bus.rd_data); else pass_cnt++;
      end
      if (c == 4) rd_done = 1'b1;
    end
    next_cycle();
    set_idle();
    @(negedge clk);
    total_cnt++; if (bus.mem_ready !== 1'b1) $display("FAIL starve_ready_end got=%0b want=1", bus.mem_ready); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] exp_tbl [3];
    logic [DATA_W-1:0] exp_d;
    exp_tbl[0] = 128'h1111;
    exp_tbl[1] = 128'h2222;
    exp_tbl[2] = 128'h3333;
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      bus.rd_req  = (c < 3);
      bus.rd_addr = (c < 3) ? 4'(c) : 4'd0;
      if (c < 3) exp_q.push_back(exp_tbl[c]);
      @(negedge clk);
      total_cnt++; if (bus.rd_gnt !== (c < 3)) $display("FAIL b2b_gnt_c%0d got=%0b want=%0b", c, bus.rd_gnt, (c < 3)); else pass_cnt++;
      total_cnt++; if (bus.rd_valid !== (c >= 2 && c <= 4)) $display("FAIL b2b_valid_c%0d got=%0b want=%0b", c, bus.rd_valid, (c >= 2 && c <= 4)); else pass_cnt++;
      if (bus.rd_valid === 1'b1) begin
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL b2b_data_c%0d got=%0h want=<none>", c, bus.rd_data);
        end else begin
          exp_d = exp_q.pop_front();
          if (bus.rd_data !== exp_d) $display("FAIL b2b_data_c%0d got=%0h want=%0h", c, bus.rd_data, exp_d);
          else pass_cnt++;
        end
      end
    end
    total_cnt++; if (exp_q.size() != 0) $display("FAIL b2b_leftover got=%0d want=0", exp_q.size()); else pass_cnt++;
    exp_q.delete();
    set_idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    pass_cnt   = 0;
    total_cnt  = 0;
    bram_stage = '0;
    bus.mem_rdata = '0;
    for (int i = 0; i < 16; i++) bram[i] = 128'(i) << 64;
    bram[0] = 128'h1111;
    bram[1] = 128'h2222;
    bram[2] = 128'h3333;
    bram[3] = 128'hABCD;
    rst = 1'b1;
    set_idle();
    repeat (2) @(posedge clk);

    test_reset();
    test_reset_mid_flight();
    test_isolated_read();
    test_write_then_read();
    test_starvation();
    test_back_to_back();

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
